// File: rtl/lane_scatter_pkg.sv
// Shared constants and state type for the lane_scatter operand distributor.
package lane_scatter_pkg;

  localparam int ACC_DATA_WIDTH  = 32;
  localparam int LANE_DATA_WIDTH = ACC_DATA_WIDTH;
  localparam int LANE_COUNT      = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } lane_scatter_state_e;

endpackage

// File: rtl/lane_scatter.sv
// Serial-to-parallel lane distributor: fills NUM_LANES lane words and presents them with a mask.
// Optional macro LANE_SCATTER_BROADCAST_EN adds in_bcast (replicate one word into all lanes).
module lane_scatter
  import lane_scatter_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_DATA_WIDTH,
  parameter int NUM_LANES  = LANE_COUNT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_last,
`ifdef LANE_SCATTER_BROADCAST_EN
  input  logic                            in_bcast,
`endif
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_lane_mask
);

  localparam int CNT_W = $clog2(NUM_LANES);

  lane_scatter_state_e state_reg, state_next;

  logic [CNT_W-1:0]                cnt_reg;
  logic [DATA_WIDTH-1:0]           fill_buf [NUM_LANES];
  logic [NUM_LANES-1:0]            hold_mask_reg;
  logic                            out_valid_reg;
  logic [NUM_LANES*DATA_WIDTH-1:0] out_data_reg;
  logic [NUM_LANES-1:0]            out_mask_reg;

  logic                            accept;
  logic                            bcast_hit;
  logic                            completing;
  logic                            slot_free;
  logic                            load_now;
  logic                            load_hold;
  logic [DATA_WIDTH-1:0]           vec [NUM_LANES];
  logic [NUM_LANES-1:0]            vec_mask;

  assign in_ready      = (state_reg == FILL);
  assign out_valid     = out_valid_reg;
  assign out_data      = out_data_reg;
  assign out_lane_mask = out_mask_reg;

  assign accept = in_valid & in_ready & ~clear;

`ifdef LANE_SCATTER_BROADCAST_EN
  assign bcast_hit = accept & in_bcast & (cnt_reg == '0);
`else
  assign bcast_hit = 1'b0;
`endif

  assign completing = accept & ((cnt_reg == CNT_W'(NUM_LANES - 1)) | in_last | bcast_hit);
  assign slot_free  = ~out_valid_reg | out_ready;
  assign load_now   = completing & slot_free;
  assign load_hold  = (state_reg == HOLD) & out_ready & ~clear;

  // Completed vector as it would look after this beat: stale lanes above cnt are forced to 0.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_vec
    localparam logic [CNT_W-1:0] LANE_IDX = CNT_W'(gi);
    assign vec[gi] = bcast_hit              ? in_data      :
                     (cnt_reg > LANE_IDX)   ? fill_buf[gi] :
                     (cnt_reg == LANE_IDX)  ? in_data      : '0;
    assign vec_mask[gi] = bcast_hit | (cnt_reg >= LANE_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = FILL;
    end else begin
      case (state_reg)
        FILL:    if (completing && !slot_free) state_next = HOLD;
        HOLD:    if (out_ready) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      hold_mask_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_mask_reg  <= '0;
      for (int i = 0; i < NUM_LANES; i++) fill_buf[i] <= '0;
    end else if (clear) begin
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_mask_reg  <= '0;
    end else begin
      if (accept) begin
        if (completing) begin
          cnt_reg <= '0;
          // Blocked vector parks in the fill buffer until the output slot frees.
          if (!slot_free) begin
            for (int i = 0; i < NUM_LANES; i++) fill_buf[i] <= vec[i];
            hold_mask_reg <= vec_mask;
          end
        end else begin
          fill_buf[cnt_reg] <= in_data;
          cnt_reg           <= cnt_reg + CNT_W'(1);
        end
      end

      if (load_now) begin
        for (int i = 0; i < NUM_LANES; i++) out_data_reg[i*DATA_WIDTH +: DATA_WIDTH] <= vec[i];
        out_mask_reg  <= vec_mask;
        out_valid_reg <= 1'b1;
      end else if (load_hold) begin
        for (int i = 0; i < NUM_LANES; i++) out_data_reg[i*DATA_WIDTH +: DATA_WIDTH] <= fill_buf[i];
        out_mask_reg  <= hold_mask_reg;
        out_valid_reg <= 1'b1;
        cnt_reg       <= '0;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_scatter.sv
// Bench for lane_scatter: vector-level scoreboard plus directed literal checks.
// Define LANE_SCATTER_BROADCAST_EN to also exercise the broadcast port.
module tb_lane_scatter;
  import lane_scatter_pkg::*;

  localparam int DW = LANE_DATA_WIDTH;
  localparam int NL = LANE_COUNT;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      in_data;
  logic               in_last;
  logic               in_bcast;
  logic               out_valid;
  logic               out_ready;
  logic [NL*DW-1:0]   out_data;
  logic [NL-1:0]      out_lane_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NL*DW-1:0] data;
    logic [NL-1:0]    mask;
  } vec_t;

  vec_t          exp_q[$];
  logic [DW-1:0] partial[$];

  always #5 clk = ~clk;

  lane_scatter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
`ifdef LANE_SCATTER_BROADCAST_EN
    .in_bcast      (in_bcast),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_lane_mask (out_lane_mask)
  );

  // Vector-level model: a queue of completed vectors, head is what the output must show.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      partial.delete();
    end else if (clear) begin
      exp_q.delete();
      partial.delete();
    end else begin
      bit   pop, acc, done, bc;
      vec_t v;
      pop  = (exp_q.size() > 0) && out_ready;
      acc  = in_valid && (exp_q.size() < 2);
      done = 1'b0;
      bc   = 1'b0;
`ifdef LANE_SCATTER_BROADCAST_EN
      bc = in_bcast && (partial.size() == 0);
`endif
      if (acc) begin
        if (bc) begin
          for (int i = 0; i < NL; i++) v.data[i*DW +: DW] = in_data;
          v.mask = '1;
          done   = 1'b1;
        end else begin
          partial.push_back(in_data);
          if (partial.size() == NL || in_last) begin
            v.data = '0;
            for (int i = 0; i < partial.size(); i++) v.data[i*DW +: DW] = partial[i];
            v.mask = NL'((1 << partial.size()) - 1);
            partial.delete();
            done = 1'b1;
          end
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (done) exp_q.push_back(v);
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL sb_out_valid t=%0t got %b exp %b", $time, out_valid, exp_q.size() > 0);
      end
      checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t got %b exp %b", $time, in_ready, exp_q.size() < 2);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (out_data !== exp_q[0].data || out_lane_mask !== exp_q[0].mask) begin
          errors++;
          $display("FAIL sb_vector t=%0t got %h/%h exp %h/%h", $time,
                   out_data, out_lane_mask, exp_q[0].data, exp_q[0].mask);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int i);
    return out_data[i*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and return #1 after the edge that accepted it.
  task automatic send(input logic [DW-1:0] d, input logic last, input logic bc);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bcast = bc;
    while (!in_ready) begin
      step();
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout data %0h in_ready 0 exp 1", d);
        break;
      end
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bcast = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bcast  = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_mask", 64'(out_lane_mask), 64'd0);
    reset_n = 1'b1;
    step();
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // 1: full vector, back-to-back
    for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0, 1'b0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_lane0", 64'(lane(0)), 64'd1);
    chk("t1_lane7", 64'(lane(7)), 64'd8);
    chk("t1_mask", 64'(out_lane_mask), 64'hFF);
    step();
    chk("t1_valid_pulse", 64'(out_valid), 64'd0);

    // 2: early close with in_last
    send(DW'(10), 1'b0, 1'b0);
    send(DW'(20), 1'b0, 1'b0);
    send(DW'(30), 1'b1, 1'b0);
    chk("t2_lane2", 64'(lane(2)), 64'd30);
    chk("t2_lane3", 64'(lane(3)), 64'd0);
    chk("t2_mask", 64'(out_lane_mask), 64'h07);
    send(DW'(40), 1'b1, 1'b0);
    chk("t2_next_lane0", 64'(lane(0)), 64'd40);
    chk("t2_next_mask", 64'(out_lane_mask), 64'h01);
    step();

    // 3: backpressure into HOLD
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'(100 + i), 1'b0, 1'b0);
    chk("t3_hold_in_ready", 64'(in_ready), 64'd0);
    chk("t3_first_lane0", 64'(lane(0)), 64'd100);
    out_ready = 1'b1;
    step();
    chk("t3_second_lane0", 64'(lane(0)), 64'd108);
    chk("t3_second_valid", 64'(out_valid), 64'd1);
    chk("t3_in_ready_back", 64'(in_ready), 64'd1);
    step();

    // 4: clear drops held vector and partial fill, and the offered word
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(DW'(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(DW'(300 + i), 1'b0, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(999);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("t4_clear_valid", 64'(out_valid), 64'd0);
    chk("t4_clear_mask", 64'(out_lane_mask), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(DW'(400 + i), 1'b0, 1'b0);
    chk("t4_lane0", 64'(lane(0)), 64'd400);
    chk("t4_mask", 64'(out_lane_mask), 64'hFF);
    step();

    // 5: async reset mid-vector and mid-HOLD
    for (int i = 0; i < 3; i++) send(DW'(500 + i), 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t5a_valid", 64'(out_valid), 64'd0);
    chk("t5a_data", 64'(out_data[63:0]), 64'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) send(DW'(600 + i), 1'b0, 1'b0);
    chk("t5a_post_lane0", 64'(lane(0)), 64'd600);
    chk("t5a_post_lane7", 64'(lane(7)), 64'd607);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'(700 + i), 1'b0, 1'b0);
    chk("t5b_hold", 64'(in_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("t5b_valid", 64'(out_valid), 64'd0);
    chk("t5b_mask", 64'(out_lane_mask), 64'd0);
    chk("t5b_data", 64'(out_data[NL*DW-1 -: 64]), 64'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();

`ifdef LANE_SCATTER_BROADCAST_EN
    // 6: broadcast at lane 0, then ignored at lane 2
    send(DW'(32'hDEAD), 1'b0, 1'b1);
    chk("t6_bcast_lane0", 64'(lane(0)), 64'hDEAD);
    chk("t6_bcast_lane7", 64'(lane(7)), 64'hDEAD);
    chk("t6_bcast_mask", 64'(out_lane_mask), 64'hFF);
    send(DW'(1), 1'b0, 1'b0);
    send(DW'(2), 1'b0, 1'b0);
    send(DW'(32'hDEAD), 1'b0, 1'b1);
    for (int i = 3; i < 8; i++) send(DW'(i), 1'b0, 1'b0);
    chk("t6_mid_lane2", 64'(lane(2)), 64'hDEAD);
    chk("t6_mid_lane0", 64'(lane(0)), 64'd1);
    chk("t6_mid_lane3", 64'(lane(3)), 64'd3);
    step();
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
